// File: rtl/lut_neuron_prog_if.sv
// lut_neuron_prog_if: load, lookup and result handshakes of the programmable LUT neuron.
// LUT_READBACK_EN adds the readback sweep signals.
interface lut_neuron_prog_if #(parameter int IN_BITS = 6, parameter int OUT_BITS = 2);
    logic cfg_clear;
    logic load_valid;
    logic load_ready;
    logic [OUT_BITS-1:0] load_data;
    logic table_ready;
    logic in_valid;
    logic in_ready;
    logic [IN_BITS-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [OUT_BITS-1:0] out_data;
`ifdef LUT_READBACK_EN
    logic rb_start;
    logic rb_valid;
    logic [OUT_BITS-1:0] rb_data;
    modport master (
        output cfg_clear, load_valid, load_data, in_valid, in_data, out_ready, rb_start,
        input load_ready, table_ready, in_ready, out_valid, out_data, rb_valid, rb_data
    );
    modport slave (
        input cfg_clear, load_valid, load_data, in_valid, in_data, out_ready, rb_start,
        output load_ready, table_ready, in_ready, out_valid, out_data, rb_valid, rb_data
    );
`else
    modport master (
        output cfg_clear, load_valid, load_data, in_valid, in_data, out_ready,
        input load_ready, table_ready, in_ready, out_valid, out_data
    );
    modport slave (
        input cfg_clear, load_valid, load_data, in_valid, in_data, out_ready,
        output load_ready, table_ready, in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/lut_neuron_prog.sv
// lut_neuron_prog: runtime-loadable LUT neuron; the table is streamed in, then lookups run with 1-cycle latency.
// Optional LUT_READBACK_EN adds an rb_start-triggered sweep that streams the whole table out.
module lut_neuron_prog #(
    parameter int IN_BITS = 6,
    parameter int OUT_BITS = 2
) (
    input logic clk,
    input logic rst,
    lut_neuron_prog_if.slave bus
);
    localparam logic [IN_BITS-1:0] LAST = '1;
    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
    state_t state;
    logic [IN_BITS-1:0] wr_addr;
    logic load_fire;
    logic in_fire;
    logic busy;
    (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem [2**IN_BITS];

    assign bus.load_ready = state == LOADING && !bus.cfg_clear;
    assign bus.table_ready = state == READY;
    assign bus.in_ready = bus.table_ready && !bus.cfg_clear && !busy && (!bus.out_valid || bus.out_ready);
    assign load_fire = bus.load_valid && bus.load_ready;
    assign in_fire = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (load_fire) mem[wr_addr] <= bus.load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            wr_addr <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
        end else if (bus.cfg_clear) begin
            state <= LOADING;
            wr_addr <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            state <= state == EMPTY ? LOADING : (load_fire && wr_addr == LAST) ? READY : state;
            if (load_fire) wr_addr <= wr_addr + 1'b1;
            if (in_fire) begin
                bus.out_valid <= 1'b1;
                bus.out_data <= mem[bus.in_data];
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef LUT_READBACK_EN
    logic rb_active;
    logic [IN_BITS-1:0] rb_addr;
    // the trailing rb_valid beat still counts as part of the sweep
    assign busy = rb_active || bus.rb_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rb_active <= 1'b0;
            rb_addr <= '0;
            bus.rb_valid <= 1'b0;
            bus.rb_data <= '0;
        end else if (bus.cfg_clear) begin
            rb_active <= 1'b0;
            bus.rb_valid <= 1'b0;
        end else begin
            bus.rb_valid <= rb_active;
            if (rb_active) begin
                bus.rb_data <= mem[rb_addr];
                rb_addr <= rb_addr + 1'b1;
                if (rb_addr == LAST) rb_active <= 1'b0;
            end else if (bus.rb_start && state == READY && !bus.rb_valid) begin
                rb_active <= 1'b1;
                rb_addr <= '0;
            end
        end
    end
`else
    assign busy = 1'b0;
`endif
endmodule

// File: tb/tb_lut_neuron_prog.sv
// tb_lut_neuron_prog: directed self-checking bench for lut_neuron_prog (readback checked when LUT_READBACK_EN is defined).
module tb_lut_neuron_prog;
    localparam int IN_BITS = 6;
    localparam int OUT_BITS = 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0;
    int failed = 0;

    lut_neuron_prog_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) bus ();
    lut_neuron_prog #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // reference table entry i = {i[5], i[0]}
    function automatic logic [1:0] pat(input int i);
        logic [5:0] a;
        a = i[5:0];
        return {a[5], a[0]};
    endfunction

    task automatic load_seq(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.load_valid = 1'b1;
            bus.load_data = pat(k);
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    task automatic lookup(input logic [5:0] a, output logic v, output logic [1:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = a;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        v = bus.out_valid;
        d = bus.out_data;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++; if (bus.load_ready !== 1'b0) begin failed++; $display("FAIL rst_load_ready got=%b exp=0", bus.load_ready); end
        tests++; if (bus.table_ready !== 1'b0) begin failed++; $display("FAIL rst_table_ready got=%b exp=0", bus.table_ready); end
        tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        tests++; if (bus.out_data !== 2'b00) begin failed++; $display("FAIL rst_out_data got=%b exp=00", bus.out_data); end
        rst = 1'b1;
        #1;
        tests++; if (bus.load_ready !== 1'b0) begin failed++; $display("FAIL empty_load_ready got=%b exp=0", bus.load_ready); end
        @(negedge clk);
        tests++; if (bus.load_ready !== 1'b1) begin failed++; $display("FAIL loading_load_ready got=%b exp=1", bus.load_ready); end
    endtask

    task automatic test_reset_mid_load;
        load_seq(20);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if (bus.load_ready !== 1'b0) begin failed++; $display("FAIL midrst_load_ready got=%b exp=0", bus.load_ready); end
        tests++; if (dut.wr_addr !== 6'd0) begin failed++; $display("FAIL midrst_wr_addr got=%0d exp=0", dut.wr_addr); end
        tests++; if (bus.table_ready !== 1'b0) begin failed++; $display("FAIL midrst_table_ready got=%b exp=0", bus.table_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
        @(negedge clk);
        tests++; if (bus.load_ready !== 1'b1) begin failed++; $display("FAIL midrst_load_ready2 got=%b exp=1", bus.load_ready); end
        load_seq(64);
        tests++; if (bus.table_ready !== 1'b1) begin failed++; $display("FAIL midrst_reload_ready got=%b exp=1", bus.table_ready); end
    endtask

    task automatic test_full_load;
        logic v;
        logic [1:0] d;
        @(negedge clk);
        bus.cfg_clear = 1'b1;
        @(negedge clk);
        bus.cfg_clear = 1'b0;
        #1;
        tests++; if (bus.table_ready !== 1'b0) begin failed++; $display("FAIL clr_table_ready got=%b exp=0", bus.table_ready); end
        tests++; if (bus.load_ready !== 1'b1) begin failed++; $display("FAIL clr_load_ready got=%b exp=1", bus.load_ready); end
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            bus.load_valid = 1'b1;
            bus.load_data = pat(k);
        end
        #1;
        tests++; if (bus.table_ready !== 1'b0) begin failed++; $display("FAIL beat63_table_ready got=%b exp=0", bus.table_ready); end
        @(negedge clk);
        bus.load_valid = 1'b0;
        tests++; if (bus.table_ready !== 1'b1) begin failed++; $display("FAIL full_table_ready got=%b exp=1", bus.table_ready); end
        tests++; if (bus.load_ready !== 1'b0) begin failed++; $display("FAIL full_load_ready got=%b exp=0", bus.load_ready); end
        lookup(6'b110011, v, d);
        tests++; if (v !== 1'b1 || d !== 2'b11) begin failed++; $display("FAIL lookup_33 got=%b/%b exp=1/11", v, d); end
        lookup(6'b000010, v, d);
        tests++; if (v !== 1'b1 || d !== 2'b00) begin failed++; $display("FAIL lookup_02 got=%b/%b exp=1/00", v, d); end
        lookup(6'b100000, v, d);
        tests++; if (v !== 1'b1 || d !== 2'b10) begin failed++; $display("FAIL lookup_20 got=%b/%b exp=1/10", v, d); end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0 || bus.out_data !== 2'b10) begin failed++; $display("FAIL idle_hold got=%b/%b exp=0/10", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 6'h31;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_data = 6'h02;
        #1;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b11) begin failed++; $display("FAIL bp_first got=%b/%b exp=1/11", bus.out_valid, bus.out_data); end
        tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b11) begin failed++; $display("FAIL bp_hold got=%b/%b exp=1/11", bus.out_valid, bus.out_data); end
        tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL bp_in_ready2 got=%b exp=0", bus.in_ready); end
        bus.out_ready = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        bus.in_data = 6'h23;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b00) begin failed++; $display("FAIL bp_second got=%b/%b exp=1/00", bus.out_valid, bus.out_data); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b11) begin failed++; $display("FAIL bp_third got=%b/%b exp=1/11", bus.out_valid, bus.out_data); end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL bp_no_dup got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_clear_contention;
        logic v;
        logic [1:0] d;
        @(negedge clk);
        bus.cfg_clear = 1'b1;
        @(negedge clk);
        bus.cfg_clear = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.load_valid = 1'b1;
            bus.load_data = pat(k);
        end
        @(negedge clk);
        bus.load_data = pat(10);
        bus.cfg_clear = 1'b1;
        #1;
        tests++; if (bus.load_ready !== 1'b0) begin failed++; $display("FAIL cc_load_ready got=%b exp=0", bus.load_ready); end
        @(negedge clk);
        bus.cfg_clear = 1'b0;
        bus.load_valid = 1'b0;
        tests++; if (dut.wr_addr !== 6'd0) begin failed++; $display("FAIL cc_wr_addr got=%0d exp=0", dut.wr_addr); end
        tests++; if (bus.table_ready !== 1'b0) begin failed++; $display("FAIL cc_table_ready got=%b exp=0", bus.table_ready); end
        load_seq(64);
        tests++; if (bus.table_ready !== 1'b1) begin failed++; $display("FAIL cc_reload_ready got=%b exp=1", bus.table_ready); end
        bus.load_valid = 1'b1;
        bus.load_data = 2'b11;
        #1;
        tests++; if (bus.load_ready !== 1'b0) begin failed++; $display("FAIL ovf_load_ready got=%b exp=0", bus.load_ready); end
        @(negedge clk);
        bus.load_valid = 1'b0;
        lookup(6'd0, v, d);
        tests++; if (v !== 1'b1 || d !== 2'b00) begin failed++; $display("FAIL ovf_entry0 got=%b/%b exp=1/00", v, d); end
        tests++; if (dut.wr_addr !== 6'd0) begin failed++; $display("FAIL ovf_wr_addr got=%0d exp=0", dut.wr_addr); end
    endtask

    task automatic test_back_to_back;
        int results;
        results = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k <= 64; k++) begin
            @(negedge clk);
            if (k > 0) begin
                if (bus.out_valid === 1'b1) results++;
                tests++; if (bus.out_data !== pat(k - 1)) begin failed++; $display("FAIL b2b_data[%0d] got=%b exp=%b", k - 1, bus.out_data, pat(k - 1)); end
            end
            if (k < 64) begin
                bus.in_valid = 1'b1;
                bus.in_data = 6'(k);
                #1;
                tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", k, bus.in_ready); end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        tests++; if (results != 64) begin failed++; $display("FAIL b2b_count got=%0d exp=64", results); end
    endtask

`ifdef LUT_READBACK_EN
    task automatic test_readback;
        int idx;
        idx = 0;
        @(negedge clk);
        bus.rb_start = 1'b1;
        @(negedge clk);
        bus.rb_start = 1'b0;
        for (int c = 0; c < 100 && idx < 64; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL rb_in_ready[%0d] got=%b exp=0", c, bus.in_ready); end
            if (bus.rb_valid === 1'b1) begin
                tests++; if (bus.rb_data !== pat(idx)) begin failed++; $display("FAIL rb_data[%0d] got=%b exp=%b", idx, bus.rb_data, pat(idx)); end
                idx++;
            end
        end
        tests++; if (idx != 64) begin failed++; $display("FAIL rb_count got=%0d exp=64", idx); end
        @(negedge clk);
        tests++; if (bus.rb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failed++; $display("FAIL rb_end got=%b/%b exp=0/1", bus.rb_valid, bus.in_ready); end
    endtask
`endif

    initial begin
        bus.cfg_clear = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
`ifdef LUT_READBACK_EN
        bus.rb_start = 1'b0;
`endif
        test_reset();
        test_reset_mid_load();
        test_full_load();
        test_backpressure();
        test_clear_contention();
        test_back_to_back();
`ifdef LUT_READBACK_EN
        test_readback();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
